fsm_run_manager: RTL and testbench
==================================

# fsm_run_manager

Host-side run sequencer that sits upstream of the pipeline FSM controller and drives the other side of its `valid_in`/`done` handshake. It launches a programmed number of test runs, waits for each run's completion pulse, and captures the per-run transition count and error flag. It hands each result to the host over a valid/ready port and keeps aggregate totals, with a watchdog that aborts a hung run.

## Interface
Parameters:
- `RUN_W`, 8: width of the run counter and run count; at most 2^RUN_W-1 runs.
- `CNT_W`, 16: width of the per-run transition count.
- `TO_W`, 16: width of the watchdog timer.
- `TIMEOUT_CYC`, 16384: maximum cycles allowed in WAIT. Must be at least 2 and at most 2^TO_W.
- `GAP_CYC`, 2: idle cycles between a result handshake and the next launch. Must be at least 1.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: host request to begin a batch; sampled only when not busy.
- `num_runs` in RUN_W: number of runs in the batch; latched when start is accepted.
- `ctrl_valid_in` out 1: launch pulse to the controller's `valid_in`.
- `ctrl_done` in 1: completion from the controller; only its rising edge is used.
- `trans_count` in CNT_W: transition count for the run; sampled on the ctrl_done rising edge.
- `err_flag` in 1: decoder mismatch for the run; sampled with trans_count.
- `res_valid` out 1: per-run result available.
- `res_ready` in 1: host accepts the result.
- `res_run` out RUN_W: index of the run, 0-based.
- `res_trans` out CNT_W: captured trans_count.
- `res_err` out 1: captured err_flag.
- `total_trans` out CNT_W+RUN_W: sum of trans_count over completed runs; cannot overflow.
- `err_runs` out RUN_W: number of runs with err_flag=1.
- `busy` out 1: a batch is in progress.
- `all_done` out 1: sticky; the batch finished or was aborted.
- `timeout_err` out 1: sticky; the batch was aborted by the watchdog.

## Operation
- States:
  - IDLE: not busy.
  - LAUNCH: ctrl_valid_in=1 for exactly one cycle.
  - WAIT: watchdog running.
  - PUSH: res_valid=1.
  - GAP: GAP_CYC cycles.
- Rising-edge detector: done_q <= ctrl_done every cycle; edge = ctrl_done & ~done_q.
- IDLE, start=1 and num_runs≠0:
  - Latch num_runs.
  - Clear run_idx, total_trans, err_runs, all_done and timeout_err.
  - Go to LAUNCH.
- IDLE, start=1 and num_runs=0: clear the totals and timeout_err, set all_done, stay in IDLE.
- start outside IDLE is ignored.
- LAUNCH: clear the timer, go to WAIT.
- WAIT, edge=1:
  - Capture trans_count into res_trans and err_flag into res_err.
  - res_run = run_idx.
  - total_trans += trans_count, zero-extended.
  - err_runs += err_flag.
  - Go to PUSH.
- WAIT, no edge, timer = TIMEOUT_CYC-1: set timeout_err and all_done, go to IDLE; nothing is pushed.
- WAIT otherwise: timer++.
- If edge and timeout occur in the same cycle, edge wins.
- Edges outside WAIT are ignored.
- PUSH:
  - res_valid=1; res_* stay stable until res_valid && res_ready.
  - On the handshake, if run_idx = latched count-1: set all_done, go to IDLE.
  - On the handshake otherwise: run_idx++, go to GAP.
- GAP: count GAP_CYC cycles, then go to LAUNCH.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - done_q, run_idx and timer 0.
- Reset mid-batch aborts immediately. ctrl_valid_in drops asynchronously, and no result is produced.
- Launch latency: start accepted at edge t gives ctrl_valid_in high for cycle t+1 only, and busy high from t+1.
- Result latency: first ctrl_done-high cycle d in WAIT gives res_valid high from d+1. total_trans and err_runs are updated at the same edge.
- Handshake at cycle p (not last run):
  - res_valid low from p+1.
  - GAP occupies p+1..p+GAP_CYC.
  - ctrl_valid_in high at p+GAP_CYC+1.
- Handshake at cycle p (last run): busy low and all_done high from p+1.
- Timeout: WAIT entered at cycle w with no edge gives IDLE, timeout_err=1 and busy=0 at cycle w+TIMEOUT_CYC.
- ctrl_done held high across several cycles counts once.
- ctrl_done already high when WAIT is entered produces no edge until it falls and rises again.

## Test plan
- **Basic batch:** num_runs=3, controller model returns trans_count 100, 200, 300 with err 0, 1, 0, res_ready tied to 1.
  - Three results with res_run 0, 1, 2.
  - total_trans=600, err_runs=1, all_done=1, busy=0.
  - Exactly 3 ctrl_valid_in pulses, each 1 cycle wide.
- **Backpressure:** res_ready=0 for 10 cycles during PUSH.
  - res_valid and res_* are stable throughout.
  - No new ctrl_valid_in pulse until 1+GAP_CYC cycles after ready rises.
- **Watchdog:** TIMEOUT_CYC=64, ctrl_done never asserted.
  - timeout_err=1 and all_done=1 exactly 64 cycles after WAIT entry.
  - res_valid is never asserted.
- **Simultaneous edge and timeout:** edge in the cycle where timer=63.
  - The result is pushed and timeout_err stays 0.
- **Level done and edge filtering:**
  - ctrl_done held high for 5 cycles: one result.
  - A ctrl_done pulse arriving during GAP is ignored.
  - start pulsed while busy is ignored.
- **Zero runs and reset:**
  - num_runs=0: all_done=1 the next cycle, no launch.
  - Reset asserted in WAIT: all outputs 0 immediately, and a new batch runs normally afterwards.

Source files
------------

// File: rtl/fsm_run_manager.sv
// fsm_run_manager: host-side run sequencer for the pipeline FSM controller.
// Launches num_runs test runs one at a time. For each run it waits for the rising
// edge of ctrl_done, captures the run's transition count and error flag, and offers
// that result to the host over a valid/ready port. It also keeps batch totals. A
// watchdog aborts the batch if a run does not complete within TIMEOUT_CYC cycles.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   start, num_runs       batch request; num_runs is latched when start is accepted in idle
//   ctrl_valid_in         one-cycle launch pulse to the controller
//   ctrl_done             controller completion; only its rising edge is used
//   trans_count, err_flag per-run controller outputs, sampled on the ctrl_done rising edge
//   res_valid, res_ready  per-run result handshake
//   res_run, res_trans,
//   res_err               captured result: run index, transition count, error flag
//   total_trans, err_runs batch totals
//   busy                  a batch is in progress
//   all_done              sticky: the batch finished or was aborted
//   timeout_err           sticky: the batch was aborted by the watchdog
`timescale 1ns/1ps
module fsm_run_manager #(
  parameter int unsigned RUN_W       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TO_W        = 16,
  parameter int unsigned TIMEOUT_CYC = 16384,
  parameter int unsigned GAP_CYC     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [RUN_W-1:0]       num_runs,
  output logic                   ctrl_valid_in,
  input  logic                   ctrl_done,
  input  logic [CNT_W-1:0]       trans_count,
  input  logic                   err_flag,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [RUN_W-1:0]       res_run,
  output logic [CNT_W-1:0]       res_trans,
  output logic                   res_err,
  output logic [CNT_W+RUN_W-1:0] total_trans,
  output logic [RUN_W-1:0]       err_runs,
  output logic                   busy,
  output logic                   all_done,
  output logic                   timeout_err
);

  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned TotW = CNT_W + RUN_W;
  localparam logic [TO_W-1:0] TimerLast = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [GapW-1:0] GapLast   = GapW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StPush,
    StGap
  } state_e;

  state_e           state_q;
  logic             done_q;
  logic [RUN_W-1:0] run_idx_q;
  logic [RUN_W-1:0] num_runs_q;
  logic [TO_W-1:0]  timer_q;
  logic [GapW-1:0]  gap_q;

  logic done_rise;
  logic last_run;

  assign done_rise = ctrl_done & ~done_q;
  assign last_run  = (run_idx_q == num_runs_q - RUN_W'(1));

  // All outputs are registered, so they are updated in the same block as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      done_q        <= 1'b0;
      run_idx_q     <= '0;
      num_runs_q    <= '0;
      timer_q       <= '0;
      gap_q         <= '0;
      ctrl_valid_in <= 1'b0;
      res_valid     <= 1'b0;
      res_run       <= '0;
      res_trans     <= '0;
      res_err       <= 1'b0;
      total_trans   <= '0;
      err_runs      <= '0;
      busy          <= 1'b0;
      all_done      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      done_q <= ctrl_done;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            total_trans <= '0;
            err_runs    <= '0;
            timeout_err <= 1'b0;
            if (num_runs != '0) begin
              num_runs_q    <= num_runs;
              run_idx_q     <= '0;
              all_done      <= 1'b0;
              busy          <= 1'b1;
              ctrl_valid_in <= 1'b1;
              state_q       <= StLaunch;
            end else begin
              // An empty batch completes immediately without a launch.
              all_done <= 1'b1;
            end
          end
        end
        StLaunch: begin
          ctrl_valid_in <= 1'b0;
          timer_q       <= '0;
          state_q       <= StWait;
        end
        StWait: begin
          // A completion edge takes priority over a watchdog expiry in the same cycle.
          if (done_rise) begin
            res_trans   <= trans_count;
            res_err     <= err_flag;
            res_run     <= run_idx_q;
            total_trans <= total_trans + TotW'(trans_count);
            err_runs    <= err_runs + RUN_W'(err_flag);
            res_valid   <= 1'b1;
            state_q     <= StPush;
          end else if (timer_q == TimerLast) begin
            timeout_err <= 1'b1;
            all_done    <= 1'b1;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            timer_q <= timer_q + TO_W'(1);
          end
        end
        StPush: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_run) begin
              all_done <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              run_idx_q <= run_idx_q + RUN_W'(1);
              gap_q     <= '0;
              state_q   <= StGap;
            end
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            ctrl_valid_in <= 1'b1;
            state_q       <= StLaunch;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_run_manager.sv
// tb_fsm_run_manager: self-checking bench for fsm_run_manager.
// A controller model answers each launch pulse. Every answered run pushes its
// expected result onto a scoreboard queue, and a monitor pops and compares that
// entry when the result handshake happens. Scenario tasks check timing and totals.
`timescale 1ns/1ps
module tb_fsm_run_manager;

  localparam int unsigned RunW       = 8;
  localparam int unsigned CntW       = 16;
  localparam int unsigned ToW        = 16;
  localparam int unsigned TimeoutCyc = 64;
  localparam int unsigned GapCyc     = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [RunW-1:0]       num_runs = '0;
  logic                  ctrl_valid_in;
  logic                  ctrl_done = 1'b0;
  logic [CntW-1:0]       trans_count = '0;
  logic                  err_flag = 1'b0;
  logic                  res_valid;
  logic                  res_ready = 1'b1;
  logic [RunW-1:0]       res_run;
  logic [CntW-1:0]       res_trans;
  logic                  res_err;
  logic [CntW+RunW-1:0]  total_trans;
  logic [RunW-1:0]       err_runs;
  logic                  busy;
  logic                  all_done;
  logic                  timeout_err;

  logic [3*RunW+2*CntW+5:0] all_outs;
  assign all_outs = {ctrl_valid_in, res_valid, res_run, res_trans, res_err, total_trans,
                     err_runs, busy, all_done, timeout_err};

  fsm_run_manager #(
    .RUN_W      (RunW),
    .CNT_W      (CntW),
    .TO_W       (ToW),
    .TIMEOUT_CYC(TimeoutCyc),
    .GAP_CYC    (GapCyc)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_runs     (num_runs),
    .ctrl_valid_in(ctrl_valid_in),
    .ctrl_done    (ctrl_done),
    .trans_count  (trans_count),
    .err_flag     (err_flag),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_run      (res_run),
    .res_trans    (res_trans),
    .res_err      (res_err),
    .total_trans  (total_trans),
    .err_runs     (err_runs),
    .busy         (busy),
    .all_done     (all_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int launches = 0;
  int results_seen = 0;
  logic [RunW-1:0] exp_run = '0;
  logic [RunW+CntW:0] exp_q[$];
  bit cv_prev = 1'b0;

  // Monitor: samples 1ns after the falling edge, so inputs driven on that edge are settled.
  always @(negedge clk) begin : mon
    logic [RunW+CntW:0] e;
    #1;
    if (!reset) begin
      if (cv_prev) begin
        checks++;
        if (ctrl_valid_in !== 1'b0) begin
          errors++;
          $display("FAIL launch_width: got ctrl_valid_in %b in second cycle, want 0", ctrl_valid_in);
        end
      end
      if (ctrl_valid_in === 1'b1 && !cv_prev) launches++;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        results_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got run %0d trans %0d err %0b, want no result",
                   res_run, res_trans, res_err);
        end else begin
          e = exp_q.pop_front();
          if ({res_run, res_trans, res_err} !== e) begin
            errors++;
            $display("FAIL result: got run %0d trans %0d err %0b, want run %0d trans %0d err %0b",
                     res_run, res_trans, res_err, e[RunW+CntW:CntW+1], e[CntW:1], e[0]);
          end
        end
      end
    end
    cv_prev = ctrl_valid_in;
  end

  task automatic start_batch(input logic [RunW-1:0] n);
    exp_run  = '0;
    num_runs = n;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({ctrl_valid_in, busy} !== 2'b11) begin
      errors++;
      $display("FAIL launch_latency: got valid/busy %b%b, want 11", ctrl_valid_in, busy);
    end
  endtask

  task automatic wait_launch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (ctrl_valid_in === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_launch: got no ctrl_valid_in within 100 cycles, want a launch");
    end
  endtask

  // Controller model: raise ctrl_done for 'hold' cycles and record the expected result.
  task automatic pulse_done(input logic [CntW-1:0] trans, input logic err, input int hold);
    ctrl_done   = 1'b1;
    trans_count = trans;
    err_flag    = err;
    exp_q.push_back({exp_run, trans, err});
    exp_run = exp_run + 1'b1;
    repeat (hold) @(negedge clk);
    ctrl_done = 1'b0;
  endtask

  task automatic check_end(input string name, input logic [CntW+RunW-1:0] tot,
                           input logic [RunW-1:0] errs);
    checks++;
    if ({total_trans, err_runs, all_done, busy} !== {tot, errs, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s_end: got total %0d errs %0d done %b busy %b, want %0d %0d 1 0",
               name, total_trans, err_runs, all_done, busy, tot, errs);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d results outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", all_outs);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, all_done, ctrl_valid_in} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got busy/done/valid %b%b%b, want 000",
               busy, all_done, ctrl_valid_in);
    end
  endtask

  task automatic test_zero_runs();
    int l0;
    l0 = launches;
    num_runs = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({all_done, busy, ctrl_valid_in, timeout_err} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_flags: got done/busy/valid/to %b%b%b%b, want 1000",
               all_done, busy, ctrl_valid_in, timeout_err);
    end
    checks++;
    if (total_trans !== '0 || err_runs !== '0) begin
      errors++;
      $display("FAIL zero_totals: got total %0d errs %0d, want 0 0", total_trans, err_runs);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (launches != l0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_launch: got %0d launches busy %b, want 0 0", launches - l0, busy);
    end
  endtask

  task automatic test_basic();
    int l0;
    bit ok;
    l0 = launches;
    res_ready = 1'b1;
    start_batch(8'd3);
    for (int r = 0; r < 3; r++) begin
      wait_launch(ok);
      repeat (3) @(negedge clk);
      pulse_done(16'(100 * (r + 1)), (r == 1), 1);
    end
    @(negedge clk);
    check_end("basic", 24'd600, 8'd1);
    checks++;
    if (launches - l0 != 3) begin
      errors++;
      $display("FAIL basic_launches: got %0d, want 3", launches - l0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    res_ready = 1'b0;
    start_batch(8'd2);
    wait_launch(ok);
    repeat (2) @(negedge clk);
    pulse_done(16'd500, 1'b1, 1);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({res_valid, res_run, res_trans, res_err, ctrl_valid_in} !==
          {1'b1, 8'd0, 16'd500, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold: got valid %b run %0d trans %0d err %b launch %b, want 1 0 500 1 0",
                 res_valid, res_run, res_trans, res_err, ctrl_valid_in);
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    for (int k = 1; k <= GapCyc + 1; k++) begin
      @(negedge clk);
      checks++;
      if ({ctrl_valid_in, res_valid} !== {(k == GapCyc + 1), 1'b0}) begin
        errors++;
        $display("FAIL bp_gap: cycle %0d got launch %b valid %b, want %b 0",
                 k, ctrl_valid_in, res_valid, (k == GapCyc + 1));
      end
    end
    wait_launch(ok);
    repeat (2) @(negedge clk);
    pulse_done(16'd20, 1'b0, 1);
    @(negedge clk);
    check_end("bp", 24'd520, 8'd1);
  endtask

  task automatic test_level_filter();
    int l0;
    int r0;
    bit ok;
    l0 = launches;
    r0 = results_seen;
    res_ready = 1'b0;
    start_batch(8'd2);
    wait_launch(ok);
    @(negedge clk);
    start = 1'b1;
    num_runs = 8'd5;
    @(negedge clk);
    start = 1'b0;
    pulse_done(16'd7, 1'b1, 5);
    res_ready = 1'b1;
    // A completion pulse while the sequencer sits in the gap must not count.
    @(negedge clk);
    ctrl_done   = 1'b1;
    trans_count = 16'hffff;
    err_flag    = 1'b1;
    @(negedge clk);
    ctrl_done = 1'b0;
    wait_launch(ok);
    repeat (2) @(negedge clk);
    pulse_done(16'd9, 1'b0, 1);
    @(negedge clk);
    check_end("level", 24'd16, 8'd1);
    checks++;
    if (launches - l0 != 2 || results_seen - r0 != 2) begin
      errors++;
      $display("FAIL level_counts: got %0d launches %0d results, want 2 2",
               launches - l0, results_seen - r0);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    res_ready = 1'b1;
    start_batch(8'd1);
    wait_launch(ok);
    for (int k = 1; k <= TimeoutCyc + 1; k++) begin
      @(negedge clk);
      checks++;
      if ({timeout_err, all_done, busy, res_valid} !==
          {(k == TimeoutCyc + 1), (k == TimeoutCyc + 1), (k != TimeoutCyc + 1), 1'b0}) begin
        errors++;
        $display("FAIL watchdog: cycle %0d got to/done/busy/valid %b%b%b%b",
                 k, timeout_err, all_done, busy, res_valid);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    res_ready = 1'b1;
    start_batch(8'd1);
    wait_launch(ok);
    repeat (TimeoutCyc) @(negedge clk);
    pulse_done(16'd77, 1'b0, 1);
    checks++;
    if ({res_valid, timeout_err, busy} !== 3'b101) begin
      errors++;
      $display("FAIL simul_push: got valid/to/busy %b%b%b, want 101",
               res_valid, timeout_err, busy);
    end
    @(negedge clk);
    check_end("simul", 24'd77, 8'd0);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_to: got timeout_err %b, want 0", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    res_ready = 1'b1;
    start_batch(8'd1);
    wait_launch(ok);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h, want 0", all_outs);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_batch(8'd1);
    wait_launch(ok);
    repeat (2) @(negedge clk);
    pulse_done(16'd42, 1'b1, 1);
    @(negedge clk);
    check_end("after_reset", 24'd42, 8'd1);
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no finish by 200us, want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench timed out");
  end

  initial begin
    test_reset();
    test_zero_runs();
    test_basic();
    test_backpressure();
    test_level_filter();
    test_watchdog();
    test_simultaneous();
    test_reset_mid();
    test_zero_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
